// File: rtl/pong_ball_engine.sv
// pong_ball_engine: ball motion, collisions, spin, scoring and
// serve / goal-pause / game-over sequencing on the game tick.
module pong_ball_engine #(
  parameter int W_SCREEN   = 800,
  parameter int H_SCREEN   = 600,
  parameter int BALL       = 10,
  parameter int PAD_LEN    = 80,
  parameter int PAD_OFS    = 20,
  parameter int PAD_W      = 10,
  parameter int SPD_X      = 2,
  parameter int SPD_Y_MAX  = 3,
  parameter int GOAL_PAUSE = 60,
  parameter int WIN_SCORE  = 9,
  parameter int SCORE_W    = 4,
  parameter int SND_PING   = 10,
  parameter int SND_PONG   = 30,
  parameter int SND_GOAL   = 40
) (
  input  logic               dyn_clk,
  input  logic               reset_n,
  input  logic               play,
  input  logic               serve,
  input  logic [9:0]         pos_ply1,
  input  logic [9:0]         pos_ply2,
  output logic [9:0]         x_ball,
  output logic [9:0]         y_ball,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               goal_ply1,
  output logic               goal_ply2,
  output logic               game_over,
  output logic               winner,
  output logic [1:0]         state,
  output logic [1:0]         sound,
  output logic [1:0]         channel
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    GPAUSE = 2'd2,
    OVER   = 2'd3
  } st_e;

  localparam logic [9:0]  X_MID = 10'((W_SCREEN - BALL) / 2);
  localparam logic [9:0]  Y_MID = 10'((H_SCREEN - BALL) / 2);
  localparam logic [10:0] X_LIM = 11'(W_SCREEN - BALL);
  localparam logic [10:0] Y_LIM = 11'(H_SCREEN - BALL);
  localparam logic [10:0] SX    = 11'(SPD_X);
  localparam logic [10:0] BL    = 11'(BALL);
  localparam logic [10:0] PL    = 11'(PAD_LEN);
  localparam logic [10:0] PL_LO = 11'(PAD_OFS);
  localparam logic [10:0] PL_HI = 11'(PAD_OFS + PAD_W);
  localparam logic [10:0] PR_LO = 11'(W_SCREEN - PAD_OFS - PAD_W);
  localparam logic [10:0] PR_HI = 11'(W_SCREEN - PAD_OFS);
  localparam logic [9:0]  XL_B  = 10'(PAD_OFS + PAD_W);
  localparam logic [9:0]  XR_B  = 10'(W_SCREEN - PAD_OFS - PAD_W - BALL);
  localparam logic signed [11:0] HB = 12'(BALL / 2);
  localparam logic signed [11:0] Q1 = 12'(PAD_LEN / 4);
  localparam logic signed [11:0] Q3 = 12'(3 * PAD_LEN / 4);
  localparam logic [2:0]  SPD_MAX = 3'(SPD_Y_MAX);
  localparam logic [15:0] P_INIT  = 16'(GOAL_PAUSE - 1);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

  st_e st_q, st_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic dx_q, dx_d, dy_q, dy_d, sdy_q, sdy_d;
  logic [2:0] spd_q, spd_d;
  logic [SCORE_W-1:0] s1_q, s1_d, s2_q, s2_d;
  logic g1_q, g1_d, g2_q, g2_d, ov_q, ov_d, win_q, win_d;
  logic [15:0] pc_q, pc_d;
  logic [1:0] snd_q, snd_d, ch_q, ch_d;
  logic [6:0] tmr_q, tmr_d;

  logic [10:0] x11, y11, xe, ye;
  logic goal_l, goal_r, hit_l, hit_r;
  logic ev_goal, ev_pong, ev_ping;
  logic signed [11:0] ofs;

  assign x11 = {1'b0, x_q};
  assign y11 = {1'b0, y_q};
  assign xe  = x11 + BL;
  assign ye  = y11 + BL;

  assign goal_l = !dx_q && (x11 <= SX);
  assign goal_r = dx_q && (x11 + SX >= X_LIM);
  assign hit_l  = !dx_q && (x11 >= PL_LO) && (x11 <= PL_HI)
               && (ye > {1'b0, pos_ply1})
               && (y11 < {1'b0, pos_ply1} + PL);
  assign hit_r  = dx_q && (xe >= PR_LO) && (xe <= PR_HI)
               && (ye > {1'b0, pos_ply2})
               && (y11 < {1'b0, pos_ply2} + PL);

  // Offset of ball centre into the paddle; zones decide the spin.
  assign ofs = $signed({2'b00, y_q}) + HB
             - $signed({2'b00, hit_l ? pos_ply1 : pos_ply2});

  always_comb begin
    st_d  = st_q;
    x_d   = x_q;
    y_d   = y_q;
    dx_d  = dx_q;
    dy_d  = dy_q;
    spd_d = spd_q;
    sdy_d = sdy_q;
    s1_d  = s1_q;
    s2_d  = s2_q;
    g1_d  = 1'b0;
    g2_d  = 1'b0;
    ov_d  = ov_q;
    win_d = win_q;
    pc_d  = pc_q;
    snd_d = snd_q;
    ch_d  = ch_q;
    tmr_d = tmr_q;
    ev_goal = 1'b0;
    ev_pong = 1'b0;
    ev_ping = 1'b0;
    unique case (st_q)
      IDLE: if (serve) st_d = RUN;
      RUN: if (play) begin
        if (goal_l || goal_r) begin
          ev_goal = 1'b1;
          x_d   = X_MID;
          y_d   = Y_MID;
          spd_d = 3'd1;
          if (goal_l) begin
            g2_d = 1'b1;
            s2_d = s2_q + 1'b1;
          end else begin
            g1_d = 1'b1;
            s1_d = s1_q + 1'b1;
          end
          if ((goal_l ? s2_d : s1_d) == WIN) begin
            st_d  = OVER;
            ov_d  = 1'b1;
            win_d = goal_l;
          end else begin
            st_d = GPAUSE;
            pc_d = P_INIT;
          end
        end else begin
          ev_pong = hit_l || hit_r;
          unique case (1'b1)
            hit_l: begin
              x_d  = XL_B;
              dx_d = 1'b1;
            end
            hit_r: begin
              x_d  = XR_B;
              dx_d = 1'b0;
            end
            default: x_d = dx_q ? x_q + 10'(SPD_X) : x_q - 10'(SPD_X);
          endcase
          if (ev_pong) begin
            if (ofs < Q1) begin
              spd_d = SPD_MAX;
              dy_d  = 1'b0;
            end else if (ofs >= Q3) begin
              spd_d = SPD_MAX;
              dy_d  = 1'b1;
            end else begin
              spd_d = 3'd1;
            end
          end
          // Wall uses the post-spin direction so corner hits bounce twice.
          if (!dy_d && (y11 <= {8'd0, spd_d})) begin
            y_d = '0;
            dy_d = 1'b1;
            ev_ping = 1'b1;
          end else if (dy_d && (y11 + {8'd0, spd_d} >= Y_LIM)) begin
            y_d = Y_LIM[9:0];
            dy_d = 1'b0;
            ev_ping = 1'b1;
          end else begin
            y_d = dy_d ? y_q + {7'd0, spd_d} : y_q - {7'd0, spd_d};
          end
        end
      end
      GPAUSE: begin
        if (pc_q == '0) begin
          st_d  = RUN;
          dy_d  = sdy_q;
          sdy_d = ~sdy_q;
        end else begin
          pc_d = pc_q - 16'd1;
        end
      end
      OVER: if (serve) begin
        s1_d = '0;
        s2_d = '0;
        ov_d = 1'b0;
        st_d = IDLE;
      end
    endcase
    if (ev_goal) begin
      snd_d = 2'd3;
      ch_d  = goal_l ? 2'd2 : 2'd1;
      tmr_d = 7'(SND_GOAL);
    end else if (ev_pong) begin
      snd_d = 2'd2;
      ch_d  = hit_l ? 2'd2 : 2'd1;
      tmr_d = 7'(SND_PONG);
    end else if (ev_ping) begin
      snd_d = 2'd1;
      ch_d  = 2'd3;
      tmr_d = 7'(SND_PING);
    end else if (tmr_q != '0) begin
      tmr_d = tmr_q - 7'd1;
      if (tmr_q == 7'd1) ch_d = 2'd0;
    end
  end

  always_ff @(posedge dyn_clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q  <= IDLE;
      x_q   <= X_MID;
      y_q   <= Y_MID;
      dx_q  <= 1'b1;
      dy_q  <= 1'b1;
      spd_q <= 3'd1;
      sdy_q <= 1'b1;
      s1_q  <= '0;
      s2_q  <= '0;
      g1_q  <= 1'b0;
      g2_q  <= 1'b0;
      ov_q  <= 1'b0;
      win_q <= 1'b0;
      pc_q  <= '0;
      snd_q <= '0;
      ch_q  <= '0;
      tmr_q <= '0;
    end else begin
      st_q  <= st_d;
      x_q   <= x_d;
      y_q   <= y_d;
      dx_q  <= dx_d;
      dy_q  <= dy_d;
      spd_q <= spd_d;
      sdy_q <= sdy_d;
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      g1_q  <= g1_d;
      g2_q  <= g2_d;
      ov_q  <= ov_d;
      win_q <= win_d;
      pc_q  <= pc_d;
      snd_q <= snd_d;
      ch_q  <= ch_d;
      tmr_q <= tmr_d;
    end
  end

  assign x_ball    = x_q;
  assign y_ball    = y_q;
  assign score1    = s1_q;
  assign score2    = s2_q;
  assign goal_ply1 = g1_q;
  assign goal_ply2 = g2_q;
  assign game_over = ov_q;
  assign winner    = win_q;
  assign state     = st_q;
  assign sound     = snd_q;
  assign channel   = ch_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
// tb_pong_ball_engine: random rallies against a behavioural model,
// plus directed serve, freeze, async-reset and game-over steps.
module tb_pong_ball_engine;
  localparam int W = 800, H = 600, B = 10, PL = 80, PO = 20, PW = 10;
  localparam int SX = 2, SYM = 3, GP = 60, WIN = 9;
  localparam int DPING = 10, DPONG = 30, DGOAL = 40;

  logic dyn_clk = 1'b0;
  logic reset_n = 1'b0;
  logic play = 1'b0;
  logic serve = 1'b0;
  logic [9:0] pos_ply1 = '0;
  logic [9:0] pos_ply2 = '0;
  logic [9:0] x_ball, y_ball;
  logic [3:0] score1, score2;
  logic goal_ply1, goal_ply2, game_over, winner;
  logic [1:0] state, sound, channel;

  int total = 0;
  int bad = 0;

  int m_x, m_y, m_dx, m_dy, m_spd, m_sdy, m_s1, m_s2, m_st;
  int m_g1, m_g2, m_ov, m_wn, m_snd, m_ch, m_tm, m_pc;
  int miss1 = 0, miss2 = 0, r1 = 40, r2 = 40, last_dx = 1;

  pong_ball_engine dut (
    .dyn_clk(dyn_clk), .reset_n(reset_n), .play(play), .serve(serve),
    .pos_ply1(pos_ply1), .pos_ply2(pos_ply2),
    .x_ball(x_ball), .y_ball(y_ball),
    .score1(score1), .score2(score2),
    .goal_ply1(goal_ply1), .goal_ply2(goal_ply2),
    .game_over(game_over), .winner(winner), .state(state),
    .sound(sound), .channel(channel)
  );

  always #5 dyn_clk = ~dyn_clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_x = (W - B) / 2; m_y = (H - B) / 2;
    m_dx = 1; m_dy = 1; m_spd = 1; m_sdy = 1;
    m_s1 = 0; m_s2 = 0; m_st = 0; m_g1 = 0; m_g2 = 0;
    m_ov = 0; m_wn = 0; m_snd = 0; m_ch = 0; m_tm = 0; m_pc = 0;
  endtask

  task automatic check_all();
    chk("x_ball", x_ball, m_x);
    chk("y_ball", y_ball, m_y);
    chk("score1", score1, m_s1);
    chk("score2", score2, m_s2);
    chk("goal_ply1", goal_ply1, m_g1);
    chk("goal_ply2", goal_ply2, m_g2);
    chk("game_over", game_over, m_ov);
    chk("winner", winner, m_wn);
    chk("state", state, m_st);
    chk("sound", sound, m_snd);
    chk("channel", channel, m_ch);
  endtask

  // Next tick from the game rules, using signed velocities.
  task automatic model_step();
    int nx, ny, ndx, ndy, nspd, nsdy, ns1, ns2, nst, ng1, ng2;
    int nov, nwn, npc, ev, evch, p, o, vy, p1, p2;
    bit hl, hr, left;
    nx = m_x; ny = m_y; ndx = m_dx; ndy = m_dy; nspd = m_spd;
    nsdy = m_sdy; ns1 = m_s1; ns2 = m_s2; nst = m_st;
    ng1 = 0; ng2 = 0; nov = m_ov; nwn = m_wn; npc = m_pc;
    ev = 0; evch = 0;
    p1 = int'(pos_ply1); p2 = int'(pos_ply2);
    if (m_st == 0) begin
      if (serve) nst = 1;
    end else if (m_st == 3) begin
      if (serve) begin ns1 = 0; ns2 = 0; nov = 0; nst = 0; end
    end else if (m_st == 2) begin
      if (m_pc == 0) begin
        nst = 1; ndy = m_sdy; nsdy = 1 - m_sdy;
      end else npc = m_pc - 1;
    end else if (play) begin
      if ((m_dx == 0 && m_x <= SX) || (m_dx == 1 && m_x + SX >= W - B)) begin
        left = (m_dx == 0);
        nx = (W - B) / 2; ny = (H - B) / 2; nspd = 1; ev = 3;
        if (left) begin ng2 = 1; ns2 = m_s2 + 1; evch = 2; end
        else begin ng1 = 1; ns1 = m_s1 + 1; evch = 1; end
        if (ns1 == WIN || ns2 == WIN) begin
          nst = 3; nov = 1; nwn = left ? 1 : 0;
        end else begin
          nst = 2; npc = GP - 1;
        end
      end else begin
        hl = m_dx == 0 && m_x >= PO && m_x <= PO + PW
          && m_y + B > p1 && m_y < p1 + PL;
        hr = m_dx == 1 && m_x + B >= W - PO - PW && m_x + B <= W - PO
          && m_y + B > p2 && m_y < p2 + PL;
        if (hl || hr) begin
          p = hl ? p1 : p2;
          if (hl) begin nx = PO + PW; ndx = 1; evch = 2; end
          else begin nx = W - PO - PW - B; ndx = 0; evch = 1; end
          ev = 2;
          o = m_y + B / 2 - p;
          if (o < 0) o = 0;
          if (o > PL - 1) o = PL - 1;
          if (o < PL / 4) begin nspd = SYM; ndy = 0; end
          else if (o >= 3 * PL / 4) begin nspd = SYM; ndy = 1; end
          else nspd = 1;
        end else begin
          nx = (m_dx == 1) ? m_x + SX : m_x - SX;
        end
        vy = (ndy == 1) ? nspd : -nspd;
        if (ndy == 0 && m_y + vy <= 0) begin
          ny = 0; ndy = 1;
          if (ev == 0) begin ev = 1; evch = 3; end
        end else if (ndy == 1 && m_y + vy >= H - B) begin
          ny = H - B; ndy = 0;
          if (ev == 0) begin ev = 1; evch = 3; end
        end else ny = m_y + vy;
      end
    end
    if (ev != 0) begin
      m_snd = ev; m_ch = evch;
      m_tm = (ev == 3) ? DGOAL : (ev == 2) ? DPONG : DPING;
    end else if (m_tm > 0) begin
      m_tm--;
      if (m_tm == 0) m_ch = 0;
    end
    m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy; m_spd = nspd;
    m_sdy = nsdy; m_s1 = ns1; m_s2 = ns2; m_st = nst;
    m_g1 = ng1; m_g2 = ng2; m_ov = nov; m_wn = nwn; m_pc = npc;
  endtask

  task automatic tick();
    model_step();
    @(posedge dyn_clk);
    #1;
    check_all();
  endtask

  function automatic logic [9:0] paddle(input int miss, input int r);
    int p;
    if (miss != 0) p = (m_y > 300) ? 0 : 700;
    else begin
      p = m_y + 9 - r;
      if (p < 0) p = 0;
    end
    return 10'(p);
  endfunction

  task automatic drive_rand();
    if (m_dx != last_dx) begin
      last_dx = m_dx;
      miss1 = int'($urandom_range(0, 1));
      miss2 = int'($urandom_range(0, 1));
      r1 = int'($urandom_range(0, 88));
      r2 = int'($urandom_range(0, 88));
    end
    pos_ply1 = paddle(miss1, r1);
    pos_ply2 = paddle(miss2, r2);
    play = ($urandom_range(0, 15) != 0);
    serve = ($urandom_range(0, 40) == 0);
  endtask

  initial begin
    int n;
    model_reset();
    repeat (2) @(posedge dyn_clk);
    #1;
    check_all();
    chk("rst_x", x_ball, 395);
    chk("rst_y", y_ball, 295);
    reset_n = 1'b1;
    tick();
    tick();
    chk("idle_hold_x", x_ball, 395);
    serve = 1'b1;
    tick();
    serve = 1'b0;
    chk("serve_state", state, 1);
    play = 1'b1;
    tick();
    chk("x_step1", x_ball, 397);
    chk("y_step1", y_ball, 296);
    tick();
    chk("x_step2", x_ball, 399);
    chk("y_step2", y_ball, 297);
    play = 1'b0;
    repeat (5) tick();
    chk("freeze_x", x_ball, 399);
    chk("freeze_y", y_ball, 297);
    play = 1'b1;

    n = 0;
    while (m_st != 2 && n < 20000) begin
      drive_rand();
      tick();
      n++;
    end
    chk("reach_pause", state, 2);
    serve = 1'b0;
    repeat (3) tick();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_rst_state", state, 0);
    chk("async_rst_x", x_ball, 395);
    @(posedge dyn_clk);
    #1;
    reset_n = 1'b1;
    check_all();

    n = 0;
    while (m_st != 3 && n < 60000) begin
      drive_rand();
      tick();
      n++;
    end
    chk("over_flag", game_over, 1);
    chk("over_state", state, 3);
    serve = 1'b0;
    tick();
    chk("over_hold", state, 3);
    serve = 1'b1;
    tick();
    serve = 1'b0;
    chk("restart_s1", score1, 0);
    chk("restart_s2", score2, 0);
    chk("restart_state", state, 0);
    tick();
    chk("restart_idle", state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
